// File: rtl/dma_capture_controller.sv
// Capture DMA: packs a 16-bit device stream into 32-bit words and writes them to memory as 16-beat AXI3 INCR bursts.
// Optional feature macro DMA_CAPTURE_BRESP_CHECK_EN: latch non-OKAY write responses on dma_err.
module dma_capture_controller #(
  parameter int FIFO_DEPTH = 64,
  parameter int AXI_ID     = 3
) (
  input  logic        clk,
  input  logic        resetn,
  output logic        irq,
  input  logic        dma_start_en,
  input  logic [31:0] dma_address,
  input  logic [31:0] dma_length,
  input  logic        dma_iack,
  output logic        dma_err,
  input  logic        valid_dev,
  output logic        ready_dev,
  input  logic [15:0] data_dev,
  output logic [3:0]  awid,
  output logic [31:0] awaddr,
  output logic [3:0]  awlen,
  output logic [2:0]  awsize,
  output logic [1:0]  awburst,
  output logic [1:0]  awlock,
  output logic [3:0]  awcache,
  output logic [2:0]  awprot,
  output logic        awvalid,
  input  logic        awready,
  output logic [3:0]  wid,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,
  input  logic [3:0]  bid,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {S_IDLE, S_AW, S_W, S_B} state_e;

  state_e      state_q;
  logic        busy_q, irq_q, half_q, awvalid_q, bready_q;
  logic [31:0] addr_q, in_rest_q, out_rest_q, awaddr_q;
  logic [15:0] pack_q;
  logic [PW-1:0] wr_q, rd_q;
  logic [CW-1:0] count_q, count_d;
  logic [3:0]  beat_q;
  logic [31:0] mem_q [FIFO_DEPTH];

  logic start_ok, accept, push, pop, b_hs;

  assign awid    = 4'(AXI_ID);
  assign wid     = 4'(AXI_ID);
  assign awlen   = 4'hF;
  assign awsize  = 3'd2;
  assign awburst = 2'b01;
  assign awlock  = 2'b00;
  assign awcache = 4'h0;
  assign awprot  = 3'd0;
  assign wstrb   = 4'hF;
  assign awvalid = awvalid_q;
  assign awaddr  = awaddr_q;
  assign bready  = bready_q;
  assign irq     = irq_q;

  // A start is only taken when fully idle, i.e. also after the previous irq has been acknowledged.
  always_comb begin
    start_ok  = dma_start_en && !busy_q && !irq_q;
    ready_dev = busy_q && (in_rest_q != 32'd0) && (count_q < CW'(FIFO_DEPTH));
    accept    = valid_dev && ready_dev;
    push      = accept && half_q;
    wvalid    = (state_q == S_W) && (count_q != '0);
    pop       = wvalid && wready;
    wdata     = wvalid ? mem_q[rd_q] : 32'd0;
    wlast     = (state_q == S_W) && (beat_q == 4'hF);
    b_hs      = bready_q && bvalid;
    count_d   = count_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= {data_dev, pack_q};
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= S_IDLE;
      busy_q     <= 1'b0;
      irq_q      <= 1'b0;
      half_q     <= 1'b0;
      awvalid_q  <= 1'b0;
      bready_q   <= 1'b0;
      addr_q     <= '0;
      in_rest_q  <= '0;
      out_rest_q <= '0;
      awaddr_q   <= '0;
      pack_q     <= '0;
      wr_q       <= '0;
      rd_q       <= '0;
      count_q    <= '0;
      beat_q     <= '0;
    end else begin
      if (accept) begin
        in_rest_q <= in_rest_q - 32'd2;
        half_q    <= !half_q;
        if (!half_q) pack_q <= data_dev;
      end
      if (push) wr_q <= wr_q + PW'(1);
      if (pop)  rd_q <= rd_q + PW'(1);
      count_q <= count_d;

      if (dma_iack && irq_q) irq_q <= 1'b0;

      // A zero-length request completes immediately without ever becoming busy.
      if (start_ok) begin
        addr_q     <= dma_address;
        in_rest_q  <= dma_length;
        out_rest_q <= dma_length;
        half_q     <= 1'b0;
        if (dma_length == 32'd0) irq_q <= 1'b1;
        else busy_q <= 1'b1;
      end

      case (state_q)
        S_IDLE: begin
          if (busy_q && (out_rest_q != 32'd0) && (count_q >= CW'(16))) begin
            state_q   <= S_AW;
            awvalid_q <= 1'b1;
            awaddr_q  <= addr_q;
          end
        end
        S_AW: begin
          if (awready) begin
            awvalid_q  <= 1'b0;
            addr_q     <= addr_q + 32'd64;
            out_rest_q <= out_rest_q - 32'd64;
            beat_q     <= '0;
            state_q    <= S_W;
          end
        end
        S_W: begin
          if (pop) begin
            beat_q <= beat_q + 4'd1;
            if (beat_q == 4'hF) begin
              state_q  <= S_B;
              bready_q <= 1'b1;
            end
          end
        end
        S_B: begin
          if (bvalid) begin
            bready_q <= 1'b0;
            state_q  <= S_IDLE;
            if (out_rest_q == 32'd0) begin
              busy_q <= 1'b0;
              irq_q  <= 1'b1;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

`ifdef DMA_CAPTURE_BRESP_CHECK_EN
  logic err_q;
  logic unused_bits;
  assign unused_bits = ^bid;
  assign dma_err     = err_q;

  // Sticky until the next accepted start so software can inspect it after the irq.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      err_q <= 1'b0;
    end else if (start_ok) begin
      err_q <= 1'b0;
    end else if (b_hs && (bresp != 2'b00)) begin
      err_q <= 1'b1;
    end
  end
`else
  logic unused_bits;
  assign unused_bits = ^{bid, bresp, b_hs};
  assign dma_err     = 1'b0;
`endif

endmodule

// File: tb/tb_dma_capture_controller.sv
// Self-checking bench for dma_capture_controller: table-driven transfers, randomized traffic, and hand-written corner sequences.
module tb_dma_capture_controller;

  localparam int DEPTH = 16;
`ifdef DMA_CAPTURE_BRESP_CHECK_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        irq, dma_err, ready_dev;
  logic        dma_start_en = 1'b0, dma_iack = 1'b0, valid_dev = 1'b0;
  logic [31:0] dma_address = '0, dma_length = '0;
  logic [15:0] data_dev = '0;
  logic [3:0]  awid, awlen, awcache, wid, wstrb;
  logic [31:0] awaddr, wdata;
  logic [2:0]  awsize, awprot;
  logic [1:0]  awburst, awlock;
  logic        awvalid, awready = 1'b0, wlast, wvalid, wready = 1'b0;
  logic [3:0]  bid = 4'd3;
  logic [1:0]  bresp = 2'b00;
  logic        bvalid = 1'b0, bready;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  dma_capture_controller #(.FIFO_DEPTH(DEPTH), .AXI_ID(3)) dut (
    .clk(clk), .resetn(resetn), .irq(irq), .dma_start_en(dma_start_en),
    .dma_address(dma_address), .dma_length(dma_length), .dma_iack(dma_iack),
    .dma_err(dma_err), .valid_dev(valid_dev), .ready_dev(ready_dev), .data_dev(data_dev),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] len;
    int          awDelay;
    int          wMode;
    int          wHold;
    int          badBurst;
    bit          midStart;
    bit          seqData;
    int          abortAt;
    int          expBursts;
    bit          expErrIfEnabled;
  } vec_t;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_irq"}, irq, 0);
    checkOutput({tag, "_err"}, dma_err, 0);
    checkOutput({tag, "_readyDev"}, ready_dev, 0);
    checkOutput({tag, "_awvalid"}, awvalid, 0);
    checkOutput({tag, "_wvalid"}, wvalid, 0);
    checkOutput({tag, "_wlast"}, wlast, 0);
    checkOutput({tag, "_bready"}, bready, 0);
    checkOutput({tag, "_awaddr"}, awaddr, 0);
    checkOutput({tag, "_wdata"}, wdata, 0);
  endtask

  // Runs one transfer against a slave/device model; the reference is the ordered halfword list and burst address arithmetic.
  task automatic applyStimulus(input vec_t v);
    logic [15:0] hw[$];
    int nHw, nWords, hwSent, wIdx, burstIdx, awWait, bDelay, bCount, cyc;
    bit bPend, irqDue, errDue, prevAwStall, prevWStall, midDone, expReady;
    logic [31:0] prevAwaddr, prevWdata, expWord;
    logic prevWlast;
    nHw = int'(v.len / 2);
    nWords = nHw / 2;
    for (int i = 0; i < nHw; i++) hw.push_back(v.seqData ? 16'(i + 1) : 16'($urandom));
    hwSent = 0; wIdx = 0; burstIdx = 0; awWait = 0; bDelay = 0; bCount = 0; cyc = 0;
    bPend = 0; irqDue = 0; errDue = 0; prevAwStall = 0; prevWStall = 0; midDone = 0;
    prevAwaddr = '0; prevWdata = '0; prevWlast = 0;

    @(negedge clk);
    dma_address = v.addr; dma_length = v.len; dma_start_en = 1'b1;
    @(negedge clk);
    dma_start_en = 1'b0;
    checkOutput("errClearOnStart", dma_err, 0);

    while (1) begin
      if (irqDue) begin
        checkOutput("irqRise", irq, 1);
        break;
      end
      if (cyc >= 4000) begin
        checks++; errors++;
        $display("[TB] FAIL timeout: got %0d words, %0d responses, expected %0d words", wIdx, bCount, nWords);
        break;
      end
      if (errDue) begin
        checkOutput("errAfterBadResp", dma_err, ERR_EN);
        errDue = 0;
      end
      if (prevAwStall) begin
        checkOutput("awvalidHeld", awvalid, 1);
        checkOutput("awaddrHeld", awaddr, prevAwaddr);
      end
      if (prevWStall) begin
        checkOutput("wvalidHeld", wvalid, 1);
        checkOutput("wdataHeld", wdata, prevWdata);
        checkOutput("wlastHeld", wlast, prevWlast);
      end

      dma_start_en = 1'b0;
      if (v.midStart && !midDone && wIdx >= 5) begin
        dma_start_en = 1'b1; dma_address = 32'h9000_0000; dma_length = 32'd64; midDone = 1;
      end

      expReady = (hwSent < nHw) && ((hwSent / 2 - wIdx) < DEPTH);
      checkOutput("readyDev", ready_dev, expReady);
      valid_dev = (hwSent >= nHw) ? 1'b1 : (v.seqData || $urandom_range(3) != 0);
      data_dev = (hwSent < nHw) ? hw[hwSent] : 16'hDEAD;
      if (valid_dev && ready_dev) hwSent++;

      awready = 1'b0;
      if (awvalid) begin
        awready = (awWait >= v.awDelay);
        awWait++;
      end
      if (awvalid && awready) begin
        checkOutput("burstCount", burstIdx < v.expBursts, 1);
        checkOutput("awaddr", awaddr, v.addr + 32'(64 * burstIdx));
        checkOutput("awConst", {awid, awlen, awsize, awburst, awlock, awcache, awprot},
                    {4'd3, 4'hF, 3'd2, 2'b01, 2'b00, 4'h0, 3'd0});
        burstIdx++;
        awWait = 0;
      end
      prevAwStall = awvalid && !awready;
      prevAwaddr = awaddr;

      bvalid = 1'b0; bresp = 2'b00;
      if (bPend) begin
        if (bDelay > 0) bDelay--;
        else begin
          bvalid = 1'b1;
          bresp = (bCount == v.badBurst) ? 2'b10 : 2'b00;
        end
      end
      if (bvalid && bready) begin
        checkOutput("irqLowAtResp", irq, 0);
        bPend = 0;
        bCount++;
        if (bresp != 2'b00) errDue = 1;
        if (bCount == v.expBursts) irqDue = 1;
      end

      if (cyc < v.wHold) wready = 1'b0;
      else if (v.wMode == 0) wready = 1'b1;
      else if (v.wMode == 1) wready = (cyc % 2 == 0);
      else wready = 1'($urandom_range(1));
      if (wvalid && wready) begin
        checkOutput("wordInRange", wIdx < nWords, 1);
        expWord = (wIdx < nWords) ? {hw[2 * wIdx + 1], hw[2 * wIdx]} : 32'hDEAD_BEEF;
        checkOutput("wdata", wdata, expWord);
        checkOutput("wlast", wlast, (wIdx % 16) == 15);
        checkOutput("wstrb", {wstrb, wid}, {4'hF, 4'd3});
        if (wIdx % 16 == 15) begin
          bPend = 1;
          bDelay = $urandom_range(2);
        end
        if (v.abortAt >= 0 && wIdx == v.abortAt) begin
          resetn = 1'b0;
          @(negedge clk);
          resetn = 1'b1;
          valid_dev = 1'b0; awready = 1'b0; wready = 1'b0; bvalid = 1'b0; dma_start_en = 1'b0;
          checkResetState("midReset");
          return;
        end
        wIdx++;
      end
      prevWStall = wvalid && !wready;
      prevWdata = wdata;
      prevWlast = wlast;

      cyc++;
      @(negedge clk);
    end

    valid_dev = 1'b0; awready = 1'b0; wready = 1'b0; bvalid = 1'b0; dma_start_en = 1'b0;
    checkOutput("wordTotal", wIdx, nWords);
    checkOutput("burstTotal", burstIdx, v.expBursts);
    checkOutput("errFinal", dma_err, ERR_EN && v.expErrIfEnabled);
    if (irqDue) begin
      dma_iack = 1'b1;
      @(negedge clk);
      dma_iack = 1'b0;
      checkOutput("irqAck", irq, 0);
    end
  endtask

  initial begin
    vec_t vecs [6];
    vec_t rv;
    logic [31:0] raddr;
    int nb;
    //           addr          len  awD wM wH  bad mid seq abort bursts err
    vecs[0] = '{32'h0000_1000, 64,  0, 0, 0,  -1, 0,  1,  -1,   1,     0};
    vecs[1] = '{32'h0000_2000, 256, 3, 1, 0,  -1, 0,  0,  -1,   4,     0};
    vecs[2] = '{32'h0000_3000, 128, 1, 2, 60, -1, 0,  0,  -1,   2,     0};
    vecs[3] = '{32'h0000_4000, 192, 0, 2, 0,  -1, 1,  0,  -1,   3,     0};
    vecs[4] = '{32'h0000_5000, 192, 2, 0, 0,  1,  0,  0,  -1,   3,     1};
    vecs[5] = '{32'h0000_6000, 128, 0, 1, 10, -1, 0,  0,  -1,   2,     0};

    repeat (2) @(negedge clk);
    checkResetState("reset");
    resetn = 1'b1;
    @(negedge clk);
    checkResetState("afterReset");

    // Zero-length request: irq next cycle, no bus traffic, later starts ignored until acknowledged.
    dma_address = 32'h0000_8000; dma_length = 32'd0; dma_start_en = 1'b1;
    @(negedge clk);
    dma_start_en = 1'b0;
    checkOutput("zeroLenIrq", irq, 1);
    checkOutput("zeroLenReady", ready_dev, 0);
    dma_length = 32'd64; dma_start_en = 1'b1;
    @(negedge clk);
    dma_start_en = 1'b0;
    checkOutput("startIgnoredWhileIrq", ready_dev, 0);
    repeat (2) begin
      @(negedge clk);
      checkOutput("zeroLenNoAw", awvalid, 0);
    end
    dma_iack = 1'b1;
    @(negedge clk);
    dma_iack = 1'b0;
    checkOutput("zeroLenAck", irq, 0);
    checkOutput("zeroLenStillIdle", ready_dev, 0);

    for (int i = 0; i < 6; i++) applyStimulus(vecs[i]);

    for (int r = 0; r < 5; r++) begin
      raddr = $urandom;
      raddr[5:0] = 6'd0;
      nb = int'($urandom_range(1, 5));
      rv = '{raddr, 32'(64 * nb), int'($urandom_range(0, 4)), 2, int'($urandom_range(0, 30)),
             int'($urandom_range(0, nb)), 0, 0, -1, nb, 1'b0};
      rv.expErrIfEnabled = (rv.badBurst < nb);
      applyStimulus(rv);
    end

    // Reset during beat 7, then a fresh transfer from an empty FIFO.
    applyStimulus('{32'h0000_7000, 64, 0, 0, 0, -1, 0, 1, 7, 1, 0});
    applyStimulus('{32'h0000_7400, 64, 1, 2, 0, -1, 0, 0, -1, 1, 0});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dma_capture_controller.md
# dma_capture_controller

Device-to-memory DMA engine: accepts a 16-bit halfword stream from a capture-type device controller, packs halfword pairs into 32-bit words, buffers them, and writes them to memory as 64-byte AXI3 INCR bursts on the write channels. It is the write-direction counterpart of the LCD read DMA and sits between a device controller and an AXI interconnect slave port. Completion is signalled by a level interrupt held until acknowledged.

## Interface
- FIFO_DEPTH, 64: word buffer depth; power of two, at least 16.
- AXI_ID, 3: constant driven on awid and wid.
- clk  in  1  clock; all logic on rising edge.
- resetn  in  1  synchronous, active-low reset.
- irq  out  1  transfer-done interrupt, level.
- dma_start_en  in  1  one-cycle start pulse.
- dma_address  in  32  destination byte address, 64-byte aligned.
- dma_length  in  32  byte count, multiple of 64.
- dma_iack  in  1  interrupt acknowledge.
- dma_err  out  1  write-response error flag (see Configuration).
- valid_dev  in  1  halfword valid from device.
- ready_dev  out  1  engine accepts halfword.
- data_dev  in  16  halfword data.
- awid/awaddr/awlen/awsize/awburst/awlock/awcache/awprot/awvalid  out  4/32/4/3/2/2/4/3/1  AXI3 AW.
- awready  in  1.
- wid/wdata/wstrb/wlast/wvalid  out  4/32/4/1/1  AXI3 W.
- wready  in  1.
- bid/bresp/bvalid  in  4/2/1; bready  out  1.

## Operation
- Constants: awlen=4'hF, awsize=3'd2, awburst=2'b01, awlock/awcache/awprot=0, wstrb=4'hF.
- dma_start_en is honoured only while idle (busy=0, including not waiting for irq to clear). It loads addr=dma_address, in_rest=dma_length, out_rest=dma_length, clears dma_err, and sets busy. While busy it is ignored.
- dma_length=0: busy is not set. irq rises on the next cycle and no AXI traffic is issued.
- Ingress:
  - ready_dev = busy & (in_rest!=0) & (fifo_count < FIFO_DEPTH).
  - The first accepted halfword goes to pack[15:0]; the second forms the word {data_dev, pack[15:0]}, which is pushed to the FIFO.
  - in_rest decrements by 2 per accepted halfword.
- Write FSM:
  - IDLE: moves to AW when busy & out_rest!=0 & fifo_count>=16.
  - AW: awvalid=1, awaddr=addr. On awready, addr+=64, out_rest-=64, beat counter cleared, go to W.
  - W: wvalid = FIFO not empty, wdata = FIFO head. A pop happens on wvalid&wready. wlast=1 on beat 15. After the handshake with wlast, go to B.
  - B: bready=1. On bvalid, go to IDLE. If out_rest==0 at that point, clear busy and set irq.
- irq: set the cycle after the final B handshake. Cleared by dma_iack; dma_iack is ignored while irq=0.
- AXI outputs are held stable while valid is high and ready is low. At most one burst is outstanding.
- Simultaneous FIFO push and pop: count unchanged. The FIFO pointers wrap modulo FIFO_DEPTH.

## Timing
- Reset values: irq=0, dma_err=0, ready_dev=0, awvalid=0, wvalid=0, wlast=0, bready=0, awaddr=0, wdata=0. FSM goes to IDLE, FIFO is emptied, busy=0.
- Reset mid-transfer: everything is abandoned immediately. No AXI completion is attempted.
- ready_dev is combinational from registered state, so a halfword is accepted in the same cycle that valid_dev&ready_dev are both high.
- Word push happens on the second halfword's handshake edge. The word is visible at the FIFO head one cycle later.
- IDLE→AW transition: one cycle after fifo_count reaches 16. Minimum burst cost with zero-wait slave: 1 AW + 16 W + 1 B cycle.
- Final irq: one cycle after the last bvalid&bready.

## Configuration
- DMA_CAPTURE_BRESP_CHECK_EN defined:
  - Any B handshake with bresp!=2'b00 sets dma_err.
  - The transfer still runs to completion and raises irq.
  - dma_err holds until the next accepted dma_start_en or reset.
- Not defined: dma_err is tied to 0 and bresp is ignored.

## Test plan
- dma_address=0x1000, dma_length=64, device sends halfwords 0x0001..0x0020 back-to-back, slave zero-wait → one burst: awaddr=0x1000, first wdata=0x00020001, last wdata=0x0020001F with wlast. irq=1 one cycle after the B handshake. 33rd valid_dev sees ready_dev=0.
- dma_length=256, wready toggling 1/0, awready delayed 3 cycles → 4 bursts at 0x2000/0x2040/0x2080/0x20C0. Data is in order and AW/W signals are stable while stalled. irq is asserted only after the 4th B. dma_iack clears irq.
- FIFO_DEPTH=16, wready held 0 → ready_dev drops once 16 words are queued. After wready releases, the stream resumes with no lost or duplicated data.
- dma_start_en pulsed mid-transfer with a different address → ignored; the original transfer completes unchanged.
- Macro defined, slave returns bresp=2'b10 on burst 2 of 3 → dma_err=1 from that B handshake onward. irq is still raised and the next start clears dma_err. Without the macro, dma_err stays 0.
- resetn=0 for one cycle during W beat 7, then a new start with dma_length=64 → all outputs return to reset values. The new transfer completes correctly from an empty FIFO.
